// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 encryption controller.
// The round indices match the constant table used by the permutation.
package ascon_pack;

   localparam int NB_PT_BLOCKS_DEFAULT = 4;

   localparam logic [3:0] P12_FIRST_ROUND = 4'd0;
   localparam logic [3:0] P6_FIRST_ROUND  = 4'd6;
   localparam logic [3:0] LAST_ROUND      = 4'd11;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      INIT,
      WAIT_AD,
      AD,
      WAIT_PT,
      PT,
      FINAL,
      END
   } ctrl_state_t;

   // A single-block message still needs a 1-bit block index.
   function automatic int block_width(input int nb_blocks);
      return (nb_blocks > 1) ? $clog2(nb_blocks) : 1;
   endfunction

endpackage

// File: rtl/round_counter.sv
// Round-constant index for the permutation: loads the first round of p12 (0)
// or p6 (6), counts up while enabled and saturates at the last round (11).
module round_counter
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       load_i,
   input  logic       load_p6_i,
   input  logic       en_i,
   output logic [3:0] round_o,
   output logic       last_round_o
);

   logic [3:0] round_reg;
   logic [3:0] round_next;

   always_comb begin
      round_next = round_reg;
      if (load_i) begin
         round_next = load_p6_i ? P6_FIRST_ROUND : P12_FIRST_ROUND;
      end else if (en_i && (round_reg != LAST_ROUND)) begin
         round_next = round_reg + 4'd1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         round_reg <= P12_FIRST_ROUND;
      end else begin
         round_reg <= round_next;
      end
   end

   assign round_o      = round_reg;
   assign last_round_o = (round_reg == LAST_ROUND);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for the ASCON-128 encryption datapath: walks the
// init, associated-data, plaintext and finalisation phases and decodes enables.
module ascon_ctrl_fsm
   import ascon_pack::*;
#(
   parameter  int NB_PT_BLOCKS = NB_PT_BLOCKS_DEFAULT,
   localparam int BLOCK_W      = block_width(NB_PT_BLOCKS)
)
(
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               data_valid_i,
   output logic [3:0]         round_o,
   output logic [BLOCK_W-1:0] block_o,
   output logic               state_sel_o,
   output logic               perm_en_o,
   output logic               xor_data_begin_o,
   output logic               xor_key_begin_o,
   output logic               xor_key_end_o,
   output logic               xor_lsb_end_o,
   output logic               cipher_en_o,
   output logic               tag_en_o,
   output logic               cipher_valid_o,
   output logic               end_o,
   output logic               busy_o
);

   localparam logic [BLOCK_W-1:0] LAST_BLOCK = BLOCK_W'(NB_PT_BLOCKS - 1);

   ctrl_state_t        state_reg, state_next;
   logic [BLOCK_W-1:0] block_reg;
   logic               cipher_valid_reg;

   logic       cnt_load, cnt_load_p6, cnt_en;
   logic       blk_clr, blk_inc;
   logic [3:0] round_cnt;
   logic       last_round;

   round_counter u_round_counter (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .load_i       (cnt_load),
      .load_p6_i    (cnt_load_p6),
      .en_i         (cnt_en),
      .round_o      (round_cnt),
      .last_round_o (last_round)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_reg        <= IDLE;
         block_reg        <= '0;
         cipher_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cipher_valid_reg <= cipher_en_o;
         if (blk_clr) begin
            block_reg <= '0;
         end else if (blk_inc) begin
            block_reg <= block_reg + 1'b1;
         end
      end
   end

   // Next state and counter controls.
   always_comb begin
      state_next  = state_reg;
      cnt_load    = 1'b0;
      cnt_load_p6 = 1'b0;
      cnt_en      = 1'b0;
      blk_clr     = 1'b0;
      blk_inc     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = LOAD;
               cnt_load   = 1'b1;
               blk_clr    = 1'b1;
            end
         end
         LOAD: begin
            state_next = INIT;
            cnt_load   = 1'b1;
         end
         INIT: begin
            cnt_en = 1'b1;
            if (last_round) state_next = WAIT_AD;
         end
         WAIT_AD: begin
            if (data_valid_i) begin
               state_next  = AD;
               cnt_load    = 1'b1;
               cnt_load_p6 = 1'b1;
            end
         end
         AD: begin
            cnt_en = 1'b1;
            if (last_round) begin
               state_next = WAIT_PT;
               blk_clr    = 1'b1;
            end
         end
         WAIT_PT: begin
            if (data_valid_i) begin
               cnt_load = 1'b1;
               if (block_reg != LAST_BLOCK) begin
                  state_next  = PT;
                  cnt_load_p6 = 1'b1;
               end else begin
                  state_next  = FINAL;
               end
            end
         end
         PT: begin
            cnt_en = 1'b1;
            if (last_round) begin
               state_next = WAIT_PT;
               blk_inc    = 1'b1;
            end
         end
         FINAL: begin
            cnt_en = 1'b1;
            if (last_round) state_next = END;
         end
         END: begin
            state_next = IDLE;
            cnt_load   = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Moore decode of datapath enables from state and round index.
   always_comb begin
      state_sel_o      = 1'b0;
      perm_en_o        = 1'b0;
      xor_data_begin_o = 1'b0;
      xor_key_begin_o  = 1'b0;
      xor_key_end_o    = 1'b0;
      xor_lsb_end_o    = 1'b0;
      cipher_en_o      = 1'b0;
      tag_en_o         = 1'b0;
      end_o            = 1'b0;
      unique case (state_reg)
         LOAD: begin
            state_sel_o = 1'b1;
            perm_en_o   = 1'b1;
         end
         INIT: begin
            perm_en_o     = 1'b1;
            xor_key_end_o = last_round;
         end
         AD: begin
            perm_en_o        = 1'b1;
            xor_data_begin_o = (round_cnt == P6_FIRST_ROUND);
            xor_lsb_end_o    = last_round;
         end
         PT: begin
            perm_en_o        = 1'b1;
            xor_data_begin_o = (round_cnt == P6_FIRST_ROUND);
            cipher_en_o      = (round_cnt == P6_FIRST_ROUND);
         end
         FINAL: begin
            perm_en_o        = 1'b1;
            xor_data_begin_o = (round_cnt == P12_FIRST_ROUND);
            cipher_en_o      = (round_cnt == P12_FIRST_ROUND);
            xor_key_begin_o  = (round_cnt == P12_FIRST_ROUND);
            xor_key_end_o    = last_round;
            tag_en_o         = last_round;
         end
         END: begin
            end_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Counters keep their values internally; IDLE presents zeros outward.
   assign round_o        = (state_reg == IDLE) ? 4'd0 : round_cnt;
   assign block_o        = (state_reg == IDLE) ? '0 : block_reg;
   assign cipher_valid_o = cipher_valid_reg;
   assign busy_o         = (state_reg != IDLE);

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: per-cycle comparison of every output
// against the hand-built phase schedule, for 4-block and 1-block messages.
module tb_ascon_ctrl_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_i;
   logic start4, dv4, start1, dv1;

   logic [3:0] round4, round1;
   logic [1:0] block4;
   logic [0:0] block1;
   logic sel4, pen4, xdb4, xkb4, xke4, xle4, cen4, ten4, cv4, end4, busy4;
   logic sel1, pen1, xdb1, xkb1, xke1, xle1, cen1, ten1, cv1, end1, busy1;

   ascon_ctrl_fsm #(.NB_PT_BLOCKS(4)) dut (
      .clock_i(clk), .reset_i(reset_i), .start_i(start4), .data_valid_i(dv4),
      .round_o(round4), .block_o(block4), .state_sel_o(sel4), .perm_en_o(pen4),
      .xor_data_begin_o(xdb4), .xor_key_begin_o(xkb4), .xor_key_end_o(xke4),
      .xor_lsb_end_o(xle4), .cipher_en_o(cen4), .tag_en_o(ten4),
      .cipher_valid_o(cv4), .end_o(end4), .busy_o(busy4)
   );

   ascon_ctrl_fsm #(.NB_PT_BLOCKS(1)) dut1 (
      .clock_i(clk), .reset_i(reset_i), .start_i(start1), .data_valid_i(dv1),
      .round_o(round1), .block_o(block1), .state_sel_o(sel1), .perm_en_o(pen1),
      .xor_data_begin_o(xdb1), .xor_key_begin_o(xkb1), .xor_key_end_o(xke1),
      .xor_lsb_end_o(xle1), .cipher_en_o(cen1), .tag_en_o(ten1),
      .cipher_valid_o(cv1), .end_o(end1), .busy_o(busy1)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Vector layout: {round[3:0], block[1:0], sel, pen, xdb, xkb, xke, xle, cen, ten, cv, end, busy}
   typedef struct {
      logic [16:0] exp;
      logic        dv;
      logic        st;
   } step_t;

   step_t q[$];

   function automatic void push(input int r, input int b,
                                input logic sel, input logic pen, input logic xdb,
                                input logic xkb, input logic xke, input logic xle,
                                input logic cen, input logic ten, input logic endo,
                                input logic busy, input logic dv, input logic st);
      step_t s;
      s.exp = {4'(r), 2'(b), sel, pen, xdb, xkb, xke, xle, cen, ten, 1'b0, endo, busy};
      s.dv  = dv;
      s.st  = st;
      q.push_back(s);
   endfunction

   function automatic logic [16:0] observed(input logic one);
      if (one)
         return {round1, 1'b0, block1, sel1, pen1, xdb1, xkb1, xke1, xle1, cen1, ten1, cv1, end1, busy1};
      return {round4, block4, sel4, pen4, xdb4, xkb4, xke4, xle4, cen4, ten4, cv4, end4, busy4};
   endfunction

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic one, input logic st, input logic dv, input logic rst);
      start4  = one ? 1'b0 : st;
      dv4     = one ? 1'b0 : dv;
      start1  = one ? st : 1'b0;
      dv1     = one ? dv : 1'b0;
      reset_i = rst;
   endtask

   // Build the expected schedule, then step one cycle per entry; entry c is cycle c.
   task automatic run(input int id, input logic one, input int nb, input int d_ad,
                      input int d_pt2, input logic ign, input int rst_at);
      logic  dflt;
      step_t tmp;
      int    d;
      dflt = ign ? 1'b0 : 1'b1;
      q.delete();
      push(0, 0, 0,0,0,0,0,0,0,0,0, 0, dflt, 1'b1);
      push(0, 0, 1,1,0,0,0,0,0,0,0, 1, dflt, 1'b0);
      for (int r = 0; r < 12; r++)
         push(r, 0, 0,1,0,0,(r == 11),0,0,0,0, 1, dflt, 1'b0);
      for (int i = 0; i < d_ad; i++)
         push(11, 0, 0,0,0,0,0,0,0,0,0, 1, 1'b0, 1'b0);
      push(11, 0, 0,0,0,0,0,0,0,0,0, 1, 1'b1, 1'b0);
      for (int r = 6; r < 12; r++)
         push(r, 0, 0,1,(r == 6),0,0,(r == 11),0,0,0, 1, dflt, 1'b0);
      for (int k = 0; k < nb; k++) begin
         d = (k == 2) ? d_pt2 : 0;
         for (int i = 0; i < d; i++)
            push(11, k, 0,0,0,0,0,0,0,0,0, 1, 1'b0, 1'b0);
         push(11, k, 0,0,0,0,0,0,0,0,0, 1, 1'b1, 1'b0);
         if (k < nb - 1) begin
            for (int r = 6; r < 12; r++)
               push(r, k, 0,1,(r == 6),0,0,0,(r == 6),0,0, 1, dflt, 1'b0);
         end else begin
            for (int r = 0; r < 12; r++)
               push(r, k, 0,1,(r == 0),(r == 0),(r == 11),0,(r == 0),(r == 11),0, 1, dflt, 1'b0);
         end
      end
      push(11, nb - 1, 0,0,0,0,0,0,0,0,1, 1, dflt, 1'b0);
      // Ciphertext-valid trails the capture enable by one cycle.
      for (int i = q.size() - 1; i > 0; i--) begin
         tmp = q[i];
         tmp.exp[2] = q[i-1].exp[4];
         q[i] = tmp;
      end
      if (ign) begin
         tmp = q[5];  tmp.st = 1'b1; q[5]  = tmp;
         tmp = q[30]; tmp.st = 1'b1; q[30] = tmp;
         tmp = q[7];  tmp.dv = 1'b1; q[7]  = tmp;
         tmp = q[24]; tmp.dv = 1'b1; q[24] = tmp;
      end
      for (int c = 0; c < q.size(); c++) begin
         if (rst_at >= 0 && c > rst_at) begin
            drive(one, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("run%0d_after_reset_c%0d", id, c), observed(one), 17'h0);
            @(posedge clk); #1;
            break;
         end
         drive(one, q[c].st, q[c].dv, (c == rst_at));
         @(negedge clk);
         check($sformatf("run%0d_c%0d", id, c), observed(one), q[c].exp);
         @(posedge clk); #1;
      end
      drive(one, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_i = 1'b1;
      start4 = 1'b0; dv4 = 1'b0; start1 = 1'b0; dv1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_nb4", observed(1'b0), 17'h0);
      check("reset_nb1", observed(1'b1), 17'h0);
      @(posedge clk); #1;
      reset_i = 1'b0;

      run(1, 1'b0, 4, 0, 0, 1'b0, -1);   // nominal
      run(2, 1'b0, 4, 5, 5, 1'b0, -1);   // late data_valid in WAIT_AD and before block 2
      run(3, 1'b0, 4, 0, 0, 1'b0, 18);   // reset during AD round 9
      run(4, 1'b0, 4, 0, 0, 1'b0, -1);   // full rerun after reset
      run(5, 1'b0, 4, 0, 0, 1'b1, -1);   // stray start/data_valid pulses
      run(6, 1'b0, 4, 0, 0, 1'b0, -1);   // back-to-back message
      run(7, 1'b1, 1, 0, 0, 1'b0, -1);   // single plaintext block

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
